fifo_write_port_arbiter: RTL and testbench
==========================================

Name: fifo_write_port_arbiter

Overview:
- Write-side controller for the asynchronous FIFO in the write clock domain.
- Round-robin arbitration between two valid/ready write requesters onto the single FIFO write port.
- Owns the write binary and Gray pointers, the write address and the write enable.
- Generates wfull, walmost_full and the fill level from the read pointer after it has been synchronized into the write domain (wq2_rptr, Gray coded).

Parameters:
- ADDRSIZE, 4: FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits; minimum 2.
- DATASIZE, 8: write data width.
- AFULL_THRESH, 12: walmost_full asserts when level >= this; range 1..2**ADDRSIZE.

Ports:
- wr_clk  in  1  write-domain clock.
- wrst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has data.
- req0_data  in  DATASIZE  requester 0 data.
- req0_ready  out  1  requester 0 beat accepted this cycle.
- req1_valid  in  1  requester 1 has data.
- req1_data  in  DATASIZE  requester 1 data.
- req1_ready  out  1  requester 1 beat accepted this cycle.
- wq2_rptr  in  ADDRSIZE+1  synchronized read pointer, Gray.
- wclken  out  1  FIFO memory write enable.
- waddr  out  ADDRSIZE  FIFO memory write address.
- wdata  out  DATASIZE  FIFO memory write data.
- wptr  out  ADDRSIZE+1  write pointer, Gray, registered (feeds the write-to-read synchronizer).
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  level >= AFULL_THRESH, registered.
- wlevel  out  ADDRSIZE+1  occupancy as seen from the write domain, registered.
- grant_id  out  1  requester served by the current accept.

Behaviour:
- Single clock wr_clk. Reset is synchronous and active-high on wrst and has priority over all other updates.
- Reset values:
  - wbin = 0, wptr = 0, wfull = 0, walmost_full = 0, wlevel = 0.
  - last_grant = 1, so requester 0 wins the first contest.
  - wclken = 0 and both readys = 0 while wrst is high.
- Arbitration (combinational, same cycle):
  - One requester valid: it is selected.
  - Both valid: the requester not equal to last_grant is selected.
  - grant_id = selected index.
- Acceptance:
  - reqN_ready = !wfull && !wrst && reqN_valid && (selected == N).
  - At most one ready is high per cycle.
  - accept = req0_ready | req1_ready.
- Write port (combinational):
  - wclken = accept; waddr = wbin[ADDRSIZE-1:0]; wdata = selected requester's data.
  - The memory captures on the same wr_clk edge. Zero-cycle latency from valid to write.
- Pointer update on accept:
  - wbin <= wbin+1, wrapping modulo 2**(ADDRSIZE+1).
  - wptr <= (wbin+1) ^ ((wbin+1)>>1).
  - last_grant <= selected.
  - With no accept, wbin, wptr and last_grant hold.
- Flags (registered every cycle from next-state values):
  - wgnext = Gray of next wbin.
  - wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - rbin = Gray-to-binary of wq2_rptr.
  - wlevel <= (wbin_next - rbin) mod 2**(ADDRSIZE+1).
  - walmost_full <= (wlevel_next >= AFULL_THRESH).
- Full: both readys are 0, valid inputs are ignored, no pointer movement.
- Full release: once wq2_rptr advances, wfull deasserts on the following edge. The first new accept happens in the cycle after deassertion. Level and flags are conservative because the read pointer is stale by the synchronizer delay; this is pessimistic only, never overflows.
- Simultaneous accept and read-pointer change in one cycle: flags use both the new wbin and the current wq2_rptr.
- Reset mid-burst: the in-flight beat is not written, pointers return to 0, and arbitration priority returns to requester 0.
- Requesters may drop valid without a handshake; the arbiter holds no lock between beats.

Test Plan:
- Reset: hold wrst 2 cycles with req0_valid=1 -> wclken=0, req0_ready=0, wptr=5'b00000, wfull=0, wlevel=0. First post-reset cycle: req0_ready=1, waddr=0.
- Fill from requester 0 (ADDRSIZE=4, wq2_rptr=0):
  - 16 consecutive beats D0..D15 -> waddr 0..15 in order.
  - walmost_full=1 in the cycle after the 12th accept.
  - After the 16th accept: wfull=1, wlevel=16, wptr=5'b11000.
  - A 17th valid sees req0_ready=0.
- Contention: both valid continuously, not full -> grant_id sequence 0,1,0,1,... with wdata alternating req0_data/req1_data. Only one of req0/req1 valid -> that one is served every cycle.
- Full release: from the full state, set wq2_rptr=5'b00001 -> wfull=0 and wlevel=15 one edge later; one accept then sets wfull=1 again with wptr=5'b11001.
- Wrap: 40 writes with wq2_rptr tracking the Gray value of wbin-2 -> wptr changes exactly one bit per accept, wraps 5'b10000 -> 5'b00000, wlevel stays 2, wfull never asserts.
- Reset mid-operation: after 7 writes, assert wrst for 1 cycle while both are valid -> no write that cycle, wptr=0, wlevel=0; the next contest grants requester 0.

Source files
------------

// File: rtl/fifo_write_port_arbiter_if.sv
// rtl/fifo_write_port_arbiter_if.sv - requester handshakes, FIFO write port and write-domain pointer/flag bundle
interface fifo_write_port_arbiter_if #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8
);
  logic                requester0_valid_unused_guard;
  logic                req0_valid;
  logic [DATASIZE-1:0] req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [DATASIZE-1:0] req1_data;
  logic                req1_ready;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wclken;
  logic [ADDRSIZE-1:0] waddr;
  logic [DATASIZE-1:0] wdata;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                grant_id;

  // master: the arbiter side, drives handshake responses and the FIFO write port
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, wq2_rptr,
    output req0_ready, req1_ready, wclken, waddr, wdata, wptr,
           wfull, walmost_full, wlevel, grant_id
  );

  // slave: requesters, memory and synchronizer around the arbiter
  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, wq2_rptr,
    input  req0_ready, req1_ready, wclken, waddr, wdata, wptr,
           wfull, walmost_full, wlevel, grant_id
  );
endinterface

// File: rtl/fifo_write_port_arbiter.sv
// rtl/fifo_write_port_arbiter.sv - round-robin write-side controller for an async FIFO
module fifo_write_port_arbiter #(
  parameter int ADDRSIZE     = 4,
  parameter int DATASIZE     = 8,
  parameter int AFULL_THRESH = 12
) (
  input logic                       wr_clk,
  input logic                       wrst,
  fifo_write_port_arbiter_if.master bus
);

  localparam logic [ADDRSIZE:0] AFULL_W = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              last_grant_q, last_grant_d;

  logic              sel;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] full_cmp;

  // Arbitration: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel = ~last_grant_q;
    end else if (bus.req1_valid) begin
      sel = 1'b1;
    end
    ready0 = !wfull_q && !wrst && bus.req0_valid && !sel;
    ready1 = !wfull_q && !wrst && bus.req1_valid && sel;
    accept = ready0 | ready1;
  end

  // Gray-to-binary of the synchronized read pointer: bit i is the xor of all Gray bits at or above i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Next pointer state and flags, all derived from the post-accept write pointer and the current read pointer.
  always_comb begin
    wbin_d       = accept ? wbin_q + 1'b1 : wbin_q;
    wptr_d       = wbin_d ^ (wbin_d >> 1);
    last_grant_d = accept ? sel : last_grant_q;
    full_cmp     = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
    wfull_d      = (wptr_d == full_cmp);
    wlevel_d     = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= AFULL_W);
  end

  // State registers; reset returns pointers to zero and hands priority back to requester 0.
  always_ff @(posedge wr_clk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      last_grant_q   <= 1'b1;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      last_grant_q   <= last_grant_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.grant_id     = sel;
  assign bus.wclken       = accept;
  assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
  assign bus.wdata        = sel ? bus.req1_data : bus.req0_data;
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;

endmodule

// File: tb/tb_fifo_write_port_arbiter.sv
// tb/tb_fifo_write_port_arbiter.sv - randomized directed bench for fifo_write_port_arbiter
module tb_fifo_write_port_arbiter;
  localparam int A = 4;
  localparam int D = 8;

  logic wr_clk = 1'b0;
  logic wrst   = 1'b1;
  always #5 wr_clk = ~wr_clk;

  fifo_write_port_arbiter_if #(.ADDRSIZE(A), .DATASIZE(D)) bus();

  fifo_write_port_arbiter #(.ADDRSIZE(A), .DATASIZE(D), .AFULL_THRESH(12)) dut (
    .wr_clk (wr_clk),
    .wrst   (wrst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counts of words written/read, modulo twice the depth.
  int m_wcnt  = 0;
  int rcnt    = 0;
  bit m_last  = 1'b1;
  bit m_full  = 1'b0;
  bit m_afull = 1'b0;
  int m_level = 0;
  logic [4:0] prev_wptr;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v0, input bit v1, input bit rst);
    logic [7:0] d0, d1;
    bit sel, acc;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    wrst           = rst;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.wq2_rptr   = gray(rcnt);
    sel = (v0 && v1) ? !m_last : v1;
    acc = !rst && !m_full && (v0 || v1);
    #3;
    chk("req0_ready", 32'(bus.req0_ready), 32'(acc && !sel));
    chk("req1_ready", 32'(bus.req1_ready), 32'(acc && sel));
    chk("wclken", 32'(bus.wclken), 32'(acc));
    if (acc) begin
      chk("waddr", 32'(bus.waddr), 32'(m_wcnt % 16));
      chk("wdata", 32'(bus.wdata), 32'(sel ? d1 : d0));
      chk("grant_id", 32'(bus.grant_id), 32'(sel));
    end
    @(posedge wr_clk);
    #1;
    if (rst) begin
      m_wcnt = 0; m_last = 1'b1; m_level = 0; m_full = 1'b0; m_afull = 1'b0;
    end else begin
      if (acc) begin
        m_wcnt = (m_wcnt + 1) % 32;
        m_last = sel;
      end
      m_level = (m_wcnt - rcnt) & 31;
      m_full  = (m_level == 16);
      m_afull = (m_level >= 12);
    end
    chk("wptr", 32'(bus.wptr), 32'(gray(m_wcnt)));
    chk("wfull", 32'(bus.wfull), 32'(m_full));
    chk("wlevel", 32'(bus.wlevel), 32'(m_level));
    chk("walmost_full", 32'(bus.walmost_full), 32'(m_afull));
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.wq2_rptr   = '0;
    @(posedge wr_clk);
    #1;

    // Reset held two cycles with requester 0 valid
    rcnt = 0;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("reset_wptr", 32'(bus.wptr), 32'h0);
    chk("reset_wlevel", 32'(bus.wlevel), 32'h0);

    // Fill from requester 0 with a stalled reader
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (i == 11) chk("afull_after_12", 32'(bus.walmost_full), 32'h1);
    end
    chk("fill_wptr", 32'(bus.wptr), 32'b11000);
    chk("fill_wlevel", 32'(bus.wlevel), 32'd16);
    chk("fill_wfull", 32'(bus.wfull), 32'h1);
    cycle(1'b1, 1'b0, 1'b0);

    // Full release by one read, then refill with a single beat
    rcnt = 1;
    cycle(1'b0, 1'b0, 1'b0);
    chk("release_wfull", 32'(bus.wfull), 32'h0);
    chk("release_wlevel", 32'(bus.wlevel), 32'd15);
    cycle(1'b1, 1'b0, 1'b0);
    chk("refill_wptr", 32'(bus.wptr), 32'b11001);
    chk("refill_wfull", 32'(bus.wfull), 32'h1);

    // Contention with a reader that keeps up
    for (int i = 0; i < 20; i++) begin
      rcnt = m_wcnt;
      cycle(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      rcnt = m_wcnt;
      cycle(1'b0, 1'b1, 1'b0);
    end

    // Wrap with the reader trailing two behind
    for (int i = 0; i < 40; i++) begin
      bit pick;
      pick = 1'($urandom_range(1));
      rcnt = (m_wcnt - 1) & 31;
      prev_wptr = bus.wptr;
      cycle(!pick, pick, 1'b0);
      chk("wrap_onebit", 32'($countones(bus.wptr ^ prev_wptr)), 32'd1);
      chk("wrap_level", 32'(bus.wlevel), 32'd2);
    end

    // Random traffic with a reader that only consumes written words
    for (int i = 0; i < 200; i++) begin
      if (((m_wcnt - rcnt) & 31) != 0 && $urandom_range(1) == 1) rcnt = (rcnt + 1) & 31;
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    end

    // Reset mid-burst while both requesters are valid
    for (int i = 0; i < 7; i++) begin
      rcnt = m_wcnt;
      cycle(1'b1, 1'b1, 1'b0);
    end
    rcnt = 0;
    cycle(1'b1, 1'b1, 1'b1);
    chk("midrst_wptr", 32'(bus.wptr), 32'h0);
    chk("midrst_wlevel", 32'(bus.wlevel), 32'h0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("midrst_first_addr_written", 32'(bus.wptr), 32'(gray(1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
